// File: rtl/countdown_timer_if.sv
`default_nettype none
// ============================================================================
// Module      : countdown_timer_if
// Description : Control and status bundle for the countdown timer.
//               The master side drives start/hold/bonus and observes the
//               remaining-time and state outputs; the slave is the timer.
// Revision    : 1.0  initial release
// ============================================================================
interface countdown_timer_if;
    logic       start;
    logic       hold;
    logic       bonus;
    logic [9:0] time_remaining;
    logic [1:0] seconds_left;
    logic       running;
    logic       expired;

    modport master (
        output start,
        output hold,
        output bonus,
        input  time_remaining,
        input  seconds_left,
        input  running,
        input  expired
    );

    modport slave (
        input  start,
        input  hold,
        input  bonus,
        output time_remaining,
        output seconds_left,
        output running,
        output expired
    );
endinterface
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : countdown_timer
// Description : Tick-based countdown timer with pause, saturating bonus and
//               restart. A prescaler divides clk into ticks; each tick in RUN
//               removes one unit of remaining time until it reaches zero.
// Revision    : 1.0  initial release
// ============================================================================
module countdown_timer #(
    parameter int CLK_DIV   = 100000,
    parameter int INIT_TIME = 750,
    parameter int BONUS     = 250
) (
    input  wire logic          clk,
    input  wire logic          rst,
    countdown_timer_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    // A divider of 1 still needs a one-bit counter to stay legal.
    localparam int                 c_PRE_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(CLK_DIV - 1);
    localparam logic [9:0]         c_INIT    = 10'(INIT_TIME);
    localparam logic [10:0]        c_BONUS   = 11'(BONUS);
    localparam logic [10:0]        c_MAX     = 11'd1023;

    state_t             state_q,   state_d;
    logic [c_PRE_W-1:0] pre_q,     pre_d;
    logic [9:0]         remain_q,  remain_d;
    logic               running_q, running_d;
    logic               expired_q, expired_d;

    logic               tick;
    logic [9:0]         base;
    logic [10:0]        sum;

    // Next-state, prescaler and remaining-time computation.
    always_comb begin
        state_d  = state_q;
        pre_d    = pre_q;
        remain_d = remain_q;
        tick     = 1'b0;
        base     = remain_q;
        sum      = {1'b0, remain_q};

        if (bus.start) begin
            // Restart wins over everything; hold is looked at again next cycle.
            state_d  = ST_RUN;
            pre_d    = '0;
            remain_d = c_INIT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    pre_d    = '0;
                    remain_d = c_INIT;
                end
                ST_RUN: begin
                    if (bus.hold) begin
                        // Freeze everything, including bonus, on the hold edge.
                        state_d = ST_PAUSE;
                    end else begin
                        tick  = (pre_q == c_PRE_MAX);
                        pre_d = tick ? '0 : pre_q + 1'b1;
                        // Remaining time is at least 1 in RUN, so no underflow.
                        base  = tick ? remain_q - 10'd1 : remain_q;
                        sum   = {1'b0, base} + (bus.bonus ? c_BONUS : 11'd0);
                        remain_d = (sum > c_MAX) ? 10'd1023 : sum[9:0];
                        // A coincident bonus always leaves time on the clock.
                        if (tick && !bus.bonus && (base == 10'd0)) begin
                            state_d = ST_EXPIRED;
                        end
                    end
                end
                ST_PAUSE: begin
                    sum      = {1'b0, remain_q} + (bus.bonus ? c_BONUS : 11'd0);
                    remain_d = (sum > c_MAX) ? 10'd1023 : sum[9:0];
                    if (!bus.hold) begin
                        state_d = ST_RUN;
                    end
                end
                ST_EXPIRED: begin
                    remain_d = 10'd0;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        running_d = (state_d == ST_RUN);
        expired_d = (state_d == ST_EXPIRED);
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pre_q     <= '0;
            remain_q  <= c_INIT;
            running_q <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            remain_q  <= remain_d;
            running_q <= running_d;
            expired_q <= expired_d;
        end
    end

    // Coarse seconds indicator decoded straight from the registered count.
    always_comb begin
        if (remain_q > 10'd500) begin
            bus.seconds_left = 2'd3;
        end else if (remain_q > 10'd250) begin
            bus.seconds_left = 2'd2;
        end else if (remain_q > 10'd0) begin
            bus.seconds_left = 2'd1;
        end else begin
            bus.seconds_left = 2'd0;
        end
    end

    assign bus.time_remaining = remain_q;
    assign bus.running        = running_q;
    assign bus.expired        = expired_q;

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_countdown_timer
// Description : Self-checking bench for countdown_timer. A cycle-level
//               reference model built from the timer's rules predicts every
//               output; directed scenarios are followed by random traffic.
// Revision    : 1.0  initial release
// ============================================================================
module tb_countdown_timer;

    localparam int CLK_DIV   = 4;
    localparam int INIT_TIME = 750;
    localparam int BONUS     = 250;

    localparam int M_IDLE    = 0;
    localparam int M_RUN     = 1;
    localparam int M_PAUSE   = 2;
    localparam int M_EXPIRED = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    int m_mode  = M_IDLE;
    int m_rem   = INIT_TIME;
    int m_phase = 0;

    countdown_timer_if u_if ();

    countdown_timer #(
        .CLK_DIV   (CLK_DIV),
        .INIT_TIME (INIT_TIME),
        .BONUS     (BONUS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_seconds(input int rem);
        if (rem > 500) return 3;
        if (rem > 250) return 2;
        if (rem > 0)   return 1;
        return 0;
    endfunction

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_rem   = INIT_TIME;
        m_phase = 0;
    endtask

    // One clock edge of the timer's behaviour, from its rules.
    task automatic model_edge();
        int nr;
        bit tk;
        if (u_if.start) begin
            m_mode  = M_RUN;
            m_rem   = INIT_TIME;
            m_phase = 0;
        end else if (m_mode == M_RUN) begin
            if (u_if.hold) begin
                m_mode = M_PAUSE;
            end else begin
                m_phase = m_phase + 1;
                tk = (m_phase == CLK_DIV);
                if (tk) m_phase = 0;
                nr = m_rem - (tk ? 1 : 0) + (u_if.bonus ? BONUS : 0);
                if (nr > 1023) nr = 1023;
                if (tk && !u_if.bonus && nr == 0) m_mode = M_EXPIRED;
                m_rem = nr;
            end
        end else if (m_mode == M_PAUSE) begin
            if (u_if.bonus) m_rem = (m_rem + BONUS > 1023) ? 1023 : m_rem + BONUS;
            if (!u_if.hold) m_mode = M_RUN;
        end
    endtask

    task automatic compare_all();
        chk("time_remaining", int'(u_if.time_remaining), m_rem);
        chk("seconds_left",   int'(u_if.seconds_left),   exp_seconds(m_rem));
        chk("running",        int'(u_if.running),        (m_mode == M_RUN) ? 1 : 0);
        chk("expired",        int'(u_if.expired),        (m_mode == M_EXPIRED) ? 1 : 0);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic pulse_start();
        u_if.start = 1'b1;
        step();
        u_if.start = 1'b0;
    endtask

    task automatic wait_rem(input int target, input int budget, input string tag);
        int n = 0;
        while (int'(u_if.time_remaining) != target && n < budget) begin
            step();
            n++;
        end
        chk(tag, int'(u_if.time_remaining), target);
    endtask

    initial begin
        int n;
        u_if.start = 1'b0;
        u_if.hold  = 1'b0;
        u_if.bonus = 1'b0;

        // Reset held, then released with no start for 100 cycles.
        repeat (2) step();
        rst = 1'b0;
        repeat (100) step();
        chk("idle_remain", int'(u_if.time_remaining), 750);
        chk("idle_seconds", int'(u_if.seconds_left), 3);

        // Full countdown to expiry and beyond.
        pulse_start();
        repeat (CLK_DIV * INIT_TIME + 20) step();
        chk("countdown_expired", int'(u_if.expired), 1);
        chk("countdown_zero", int'(u_if.time_remaining), 0);

        // Pause at 600 for 40 cycles, then resume.
        pulse_start();
        wait_rem(600, 1000, "reach_600");
        u_if.hold = 1'b1;
        repeat (40) step();
        chk("pause_hold_600", int'(u_if.time_remaining), 600);
        u_if.hold = 1'b0;
        repeat (20) step();

        // Bonus saturation and bonus coinciding with a tick.
        pulse_start();
        u_if.bonus = 1'b1;
        step();
        u_if.bonus = 1'b0;
        chk("bonus_750", int'(u_if.time_remaining), 1000);
        wait_rem(900, 1000, "reach_900");
        u_if.bonus = 1'b1;
        step();
        u_if.bonus = 1'b0;
        chk("bonus_saturate", int'(u_if.time_remaining), 1023);
        n = 0;
        while (!(m_rem == 10 && m_phase == CLK_DIV - 1) && n < 6000) begin
            step();
            n++;
        end
        chk("reach_10_pretick", int'(u_if.time_remaining), 10);
        u_if.bonus = 1'b1;
        step();
        u_if.bonus = 1'b0;
        chk("bonus_on_tick", int'(u_if.time_remaining), 259);
        chk("bonus_on_tick_run", int'(u_if.running), 1);

        // Restart from RUN, from EXPIRED, and with hold in the same cycle.
        wait_rem(123, 2000, "reach_123");
        pulse_start();
        chk("restart_run_remain", int'(u_if.time_remaining), 750);
        chk("restart_run_running", int'(u_if.running), 1);
        n = 0;
        while (!u_if.expired && n < 4000) begin
            step();
            n++;
        end
        chk("reach_expired", int'(u_if.expired), 1);
        pulse_start();
        chk("restart_exp_remain", int'(u_if.time_remaining), 750);
        chk("restart_exp_running", int'(u_if.running), 1);
        u_if.hold = 1'b1;
        pulse_start();
        chk("start_hold_running", int'(u_if.running), 1);
        step();
        chk("start_hold_paused", int'(u_if.running), 0);
        chk("start_hold_remain", int'(u_if.time_remaining), 750);
        u_if.hold = 1'b0;
        step();

        // Asynchronous reset between edges at 400.
        wait_rem(400, 2000, "reach_400");
        #2;
        rst = 1'b1;
        #1;
        chk("async_remain",  int'(u_if.time_remaining), 750);
        chk("async_seconds", int'(u_if.seconds_left), 3);
        chk("async_running", int'(u_if.running), 0);
        chk("async_expired", int'(u_if.expired), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (10) step();

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            u_if.start = ($urandom_range(0, 199) == 0);
            u_if.bonus = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 29) == 0) u_if.hold = ~u_if.hold;
            step();
        end
        u_if.start = 1'b0;
        u_if.bonus = 1'b0;
        u_if.hold  = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
